// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl
// ------------
// Computes y = x^e mod m using left-to-right square-and-multiply. Every
// multiply is a Montgomery multiply (R = 2^64) performed by an external
// multiplier. The block converts the operands into the Montgomery domain
// on the way in and back out again, so x and y are ordinary residues.
//
// Ports
//   pclk, nreset      clock and synchronous active-low reset
//   start             one-cycle request, only honoured in IDLE
//   x, e, m           base, exponent and odd modulus (x < m)
//   r_mod, r2_mod     R mod m and R^2 mod m, supplied by software
//   busy              high while an exponentiation is in progress
//   done              one-cycle pulse when y (and err) are valid
//   err               set with done when the modulus was even
//   y                 result, held until it is next overwritten
//   mm_go             multiplier request, held for the whole operation
//   mm_a, mm_b, mm_m  multiplier operands, stable while mm_go is high
//   mm_p, mm_ready    multiplier result and its valid flag

module mod_exp_ctrl #(
    parameter int EW = 64
) (
    input  logic          pclk,
    input  logic          nreset,
    input  logic          start,
    input  logic [63:0]   x,
    input  logic [EW-1:0] e,
    input  logic [63:0]   m,
    input  logic [63:0]   r_mod,
    input  logic [63:0]   r2_mod,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [63:0]   y,
    output logic          mm_go,
    output logic [63:0]   mm_a,
    output logic [63:0]   mm_b,
    output logic [63:0]   mm_m,
    input  logic [65:0]   mm_p,
    input  logic          mm_ready
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONV_IN,
        SCAN,
        SQR,
        MUL,
        CONV_OUT,
        DONE
    } state_t;

    state_t        state,   state_nxt;
    logic [63:0]   x_q,     x_q_nxt;
    logic [EW-1:0] e_q,     e_q_nxt;
    logic [63:0]   m_q,     m_q_nxt;
    logic [63:0]   r_q,     r_q_nxt;
    logic [63:0]   r2_q,    r2_q_nxt;
    logic [63:0]   xm,      xm_nxt;
    logic [63:0]   acc,     acc_nxt;
    logic          started, started_nxt;
    logic [IW-1:0] idx,     idx_nxt;
    logic          busy_nxt, done_nxt, err_nxt, mm_go_nxt;
    logic [63:0]   y_nxt, mm_a_nxt, mm_b_nxt, mm_m_nxt;

    // The multiplier guarantees P < M, so the two top bits carry nothing.
    logic [63:0] p_lo;
    logic        unused_p_hi;
    logic        op_done;

    assign p_lo        = mm_p[63:0];
    assign unused_p_hi = ^mm_p[65:64];
    assign op_done     = mm_go && mm_ready;

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state   <= IDLE;
            x_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            r2_q    <= '0;
            xm      <= '0;
            acc     <= '0;
            started <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            y       <= '0;
            mm_go   <= 1'b0;
            mm_a    <= '0;
            mm_b    <= '0;
            mm_m    <= '0;
        end else begin
            state   <= state_nxt;
            x_q     <= x_q_nxt;
            e_q     <= e_q_nxt;
            m_q     <= m_q_nxt;
            r_q     <= r_q_nxt;
            r2_q    <= r2_q_nxt;
            xm      <= xm_nxt;
            acc     <= acc_nxt;
            started <= started_nxt;
            idx     <= idx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            y       <= y_nxt;
            mm_go   <= mm_go_nxt;
            mm_a    <= mm_a_nxt;
            mm_b    <= mm_b_nxt;
            mm_m    <= mm_m_nxt;
        end
    end

    // Operation handshake: an op state whose mm_go is low loads the operands
    // and raises mm_go in the same edge; once mm_ready is seen the result is
    // captured and mm_go drops. The cycle spent in the following state with
    // mm_go low is the one-cycle gap the multiplier needs to clear itself.
    // SCAN launches the square directly so the gap after a multiply that
    // returns through SCAN is still exactly one cycle.
    always_comb begin
        state_nxt   = state;
        x_q_nxt     = x_q;
        e_q_nxt     = e_q;
        m_q_nxt     = m_q;
        r_q_nxt     = r_q;
        r2_q_nxt    = r2_q;
        xm_nxt      = xm;
        acc_nxt     = acc;
        started_nxt = started;
        idx_nxt     = idx;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;
        y_nxt       = y;
        mm_go_nxt   = mm_go;
        mm_a_nxt    = mm_a;
        mm_b_nxt    = mm_b;
        mm_m_nxt    = mm_m;

        case (state)
            IDLE: begin
                if (start) begin
                    x_q_nxt  = x;
                    e_q_nxt  = e;
                    m_q_nxt  = m;
                    r_q_nxt  = r_mod;
                    r2_q_nxt = r2_mod;
                    err_nxt  = 1'b0;
                    if (!m[0]) begin
                        // Montgomery arithmetic needs an odd modulus.
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        y_nxt     = '0;
                    end else begin
                        state_nxt = CONV_IN;
                        busy_nxt  = 1'b1;
                    end
                end
            end

            CONV_IN: begin
                if (!mm_go) begin
                    mm_a_nxt  = x_q;
                    mm_b_nxt  = r2_q;
                    mm_m_nxt  = m_q;
                    mm_go_nxt = 1'b1;
                end else if (op_done) begin
                    mm_go_nxt   = 1'b0;
                    xm_nxt      = p_lo;
                    acc_nxt     = r_q;
                    started_nxt = 1'b0;
                    idx_nxt     = IW'(EW - 1);
                    state_nxt   = SCAN;
                end
            end

            SCAN: begin
                if (started) begin
                    mm_a_nxt  = acc;
                    mm_b_nxt  = acc;
                    mm_m_nxt  = m_q;
                    mm_go_nxt = 1'b1;
                    state_nxt = SQR;
                end else begin
                    // The top set bit just loads xm: squaring and multiplying
                    // the Montgomery one would waste two operations.
                    if (e_q[idx]) begin
                        acc_nxt     = xm;
                        started_nxt = 1'b1;
                    end
                    if (idx == '0) begin
                        state_nxt = CONV_OUT;
                    end else begin
                        idx_nxt = idx - IW'(1);
                    end
                end
            end

            SQR: begin
                if (op_done) begin
                    mm_go_nxt = 1'b0;
                    acc_nxt   = p_lo;
                    if (e_q[idx]) begin
                        state_nxt = MUL;
                    end else if (idx == '0) begin
                        state_nxt = CONV_OUT;
                    end else begin
                        idx_nxt   = idx - IW'(1);
                        state_nxt = SCAN;
                    end
                end
            end

            MUL: begin
                if (!mm_go) begin
                    mm_a_nxt  = acc;
                    mm_b_nxt  = xm;
                    mm_m_nxt  = m_q;
                    mm_go_nxt = 1'b1;
                end else if (op_done) begin
                    mm_go_nxt = 1'b0;
                    acc_nxt   = p_lo;
                    if (idx == '0) begin
                        state_nxt = CONV_OUT;
                    end else begin
                        idx_nxt   = idx - IW'(1);
                        state_nxt = SCAN;
                    end
                end
            end

            CONV_OUT: begin
                // Multiplying by plain 1 strips the R factor.
                if (!mm_go) begin
                    mm_a_nxt  = acc;
                    mm_b_nxt  = 64'd1;
                    mm_m_nxt  = m_q;
                    mm_go_nxt = 1'b1;
                end else if (op_done) begin
                    mm_go_nxt = 1'b0;
                    y_nxt     = p_lo;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                mm_go_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl
// ---------------
// Directed bench for mod_exp_ctrl. A behavioural Montgomery multiplier
// (A*B*2^-64 mod M, random latency, junk in the top result bits) answers
// the block's requests; a monitor counts operations, done pulses and any
// operand change while mm_go is high.

module tb_mod_exp_ctrl;

    localparam int EW = 64;
    localparam logic [63:0] MOD   = 64'hFFFF_FFFF_FFFF_FFC5;
    localparam logic [63:0] RMOD  = 64'h3B;
    localparam logic [63:0] R2MOD = 64'hD99;

    logic          pclk   = 1'b0;
    logic          nreset = 1'b0;
    logic          start  = 1'b0;
    logic [63:0]   x      = '0;
    logic [EW-1:0] e      = '0;
    logic [63:0]   m      = '0;
    logic [63:0]   r_mod  = '0;
    logic [63:0]   r2_mod = '0;
    logic          busy, done, err, mm_go;
    logic [63:0]   y, mm_a, mm_b, mm_m;
    logic [65:0]   mm_p     = '0;
    logic          mm_ready = 1'b0;

    int assertCount = 0;
    int failCount   = 0;
    int opsCount    = 0;
    int doneCount   = 0;
    int stableErr   = 0;

    mod_exp_ctrl #(.EW(EW)) dut (
        .pclk     (pclk),
        .nreset   (nreset),
        .start    (start),
        .x        (x),
        .e        (e),
        .m        (m),
        .r_mod    (r_mod),
        .r2_mod   (r2_mod),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .y        (y),
        .mm_go    (mm_go),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_m     (mm_m),
        .mm_p     (mm_p),
        .mm_ready (mm_ready)
    );

    always #5 pclk = ~pclk;

    // Bit-serial Montgomery product: a*b*2^-64 mod md.
    function automatic logic [63:0] montMul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] md);
        logic [65:0] t;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, md};
            t = t >> 1;
        end
        if (t >= {2'b00, md}) t = t - {2'b00, md};
        return t[63:0];
    endfunction

    // Multiplier model and bus monitor, both working on the falling edge.
    int           latency = 0;
    int           waitCnt = 0;
    logic         prevGo  = 1'b0;
    logic [191:0] snap    = '0;

    always @(negedge pclk) begin
        if (!mm_go) begin
            mm_ready = 1'b0;
            waitCnt  = 0;
            latency  = $urandom_range(0, 3);
        end else if (!mm_ready) begin
            if (waitCnt >= latency) begin
                mm_ready = 1'b1;
                mm_p     = {2'b10, montMul(mm_a, mm_b, mm_m)};
            end else begin
                waitCnt++;
            end
        end
        if (mm_go && !prevGo) opsCount++;
        if (mm_go && prevGo && ({mm_a, mm_b, mm_m} !== snap)) stableErr++;
        if (mm_go) snap = {mm_a, mm_b, mm_m};
        if (done) doneCount++;
        prevGo = mm_go;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounters();
        opsCount  = 0;
        doneCount = 0;
        stableErr = 0;
    endtask

    // Drive a request and pulse start for one cycle.
    task automatic applyStimulus(input logic [63:0] xi, input logic [EW-1:0] ei,
                                 input logic [63:0] mi);
        x      = xi;
        e      = ei;
        m      = mi;
        r_mod  = RMOD;
        r2_mod = R2MOD;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic runCase(input string tag, input logic [63:0] xi, input logic [EW-1:0] ei,
                           input logic [63:0] mi, input logic [63:0] expY,
                           input logic expErr, input int expOps);
        clearCounters();
        applyStimulus(xi, ei, mi);
        checkOutput({tag, "_busy_after_start"}, 64'(busy), expErr ? 64'd0 : 64'd1);
        waitDone(tag);
        checkOutput({tag, "_y"}, y, expY);
        checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
        repeat (3) tick();
        checkOutput({tag, "_ops"}, 64'(opsCount), 64'(expOps));
        checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'd1);
        checkOutput({tag, "_operand_stable"}, 64'(stableErr), 64'd0);
        checkOutput({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        checkOutput({tag, "_y_held"}, y, expY);
    endtask

    initial begin
        bit reached;

        nreset = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_y", y, 64'd0);
        checkOutput("reset_mm_go", 64'(mm_go), 64'd0);
        checkOutput("reset_mm_a", mm_a, 64'd0);
        checkOutput("reset_mm_b", mm_b, 64'd0);
        checkOutput("reset_mm_m", mm_m, 64'd0);
        nreset = 1'b1;
        tick();

        // 2^10: top bit at 3, two set bits -> 2 + 3 + 1 operations.
        runCase("pow2_10", 64'd2, 64'd10, MOD, 64'h400, 1'b0, 6);
        runCase("e_zero", 64'd3, 64'd0, MOD, 64'd1, 1'b0, 2);
        runCase("e_one", 64'd5, 64'd1, MOD, 64'd5, 1'b0, 2);
        // Fermat: M is prime, so 3^(M-1) = 1; 2 + 63 + 58 operations.
        runCase("fermat", 64'd3, MOD - 64'd1, MOD, 64'd1, 1'b0, 123);

        // Even modulus: done the cycle after accept, no multiplies.
        clearCounters();
        applyStimulus(64'd3, 64'd7, 64'h10);
        checkOutput("even_done_next_cycle", 64'(done), 64'd1);
        checkOutput("even_err", 64'(err), 64'd1);
        checkOutput("even_y", y, 64'd0);
        checkOutput("even_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("even_ops", 64'(opsCount), 64'd0);
        checkOutput("even_done_pulses", 64'(doneCount), 64'd1);
        checkOutput("even_err_held", 64'(err), 64'd1);

        // The next valid start clears err as soon as it is accepted.
        clearCounters();
        applyStimulus(64'd5, 64'd1, MOD);
        checkOutput("err_cleared_on_start", 64'(err), 64'd0);
        waitDone("after_even");
        checkOutput("after_even_y", y, 64'd5);
        checkOutput("after_even_err", 64'(err), 64'd0);
        repeat (3) tick();

        // Reset while the first square is in flight (second operation).
        clearCounters();
        applyStimulus(64'd2, 64'd10, MOD);
        reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            if (opsCount >= 2) reached = 1'b1;
            else tick();
        end
        checkOutput("rst_reached_sqr", 64'(reached), 64'd1);
        nreset = 1'b0;
        tick();
        checkOutput("rst_mm_go", 64'(mm_go), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        nreset = 1'b1;
        tick();
        runCase("rst_rerun", 64'd2, 64'd10, MOD, 64'h400, 1'b0, 6);

        // A second start while busy, with changed inputs, must be ignored.
        clearCounters();
        applyStimulus(64'd2, 64'd10, MOD);
        repeat (5) tick();
        applyStimulus(64'd3, 64'd5, MOD);
        x = 64'd7;
        e = 64'd3;
        waitDone("busy_start");
        checkOutput("busy_start_y", y, 64'h400);
        repeat (3) tick();
        checkOutput("busy_start_ops", 64'(opsCount), 64'd6);
        checkOutput("busy_start_done_pulses", 64'(doneCount), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
